// File: rtl/sonar_uc_pkg.sv
// sonar_uc_pkg: shared constants for the sonar sweep control unit.
//   - 4-bit state codes reported on db_estado
//   - default number of measurement retries after an echo timeout
//   - number of characters in one "AAA,DDD#" frame
package sonar_uc_pkg;

  localparam logic [3:0] INICIAL        = 4'd0;
  localparam logic [3:0] ESPERA         = 4'd1;
  localparam logic [3:0] MEDE           = 4'd2;
  localparam logic [3:0] AGUARDA_MEDIDA = 4'd3;
  localparam logic [3:0] FALHA_ECHO     = 4'd4;
  localparam logic [3:0] TRANSMITE      = 4'd5;
  localparam logic [3:0] AGUARDA_TX     = 4'd6;
  localparam logic [3:0] PROXIMO        = 4'd7;
  localparam logic [3:0] AVANCA         = 4'd8;

  localparam int MAX_RETRIES_DEFAULT = 2;
  localparam int FRAME_LEN           = 8;

endpackage

// File: rtl/sonar_uc.sv
// sonar_uc: control unit for the sonar sweep datapath.
// Each sweep step (started by a 2 s pulse) performs one distance measurement,
// sends the 8-character frame one character at a time, then advances the
// servo angle. Echo timeouts are retried up to MAX_RETRIES times; once the
// retries are exhausted the angle is skipped and db_falha is latched.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   ligar                   sweep enable (honoured only while waiting)
//   pronto_medida           measurement done pulse
//   timeout_echo            echo timeout reached
//   pronto_transmissao      character sent pulse
//   fim_serial              ASCII selector at the last character
//   dois_segundos           2 s interval pulse
//   reset_circuito .. conta_angulo   datapath control strobes (Moore outputs)
//   db_falha                sticky skipped-angle flag
//   db_estado               current state code
//
// state          | meaning
// INICIAL   (0)  | idle, datapath held cleared
// ESPERA    (1)  | enabled, waiting for the 2 s pulse
// MEDE      (2)  | fire one measurement, clear echo timeout
// AGUARDA_MEDIDA (3) | wait for measurement or echo timeout
// FALHA_ECHO(4)  | timeout: retry or give up on this angle
// TRANSMITE (5)  | start sending the current character
// AGUARDA_TX(6)  | wait for the character to finish
// PROXIMO   (7)  | step the ASCII selector, loop or finish frame
// AVANCA    (8)  | advance servo angle
module sonar_uc
  import sonar_uc_pkg::*;
#(
  parameter int MAX_RETRIES = MAX_RETRIES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_medida,
  input  logic       timeout_echo,
  input  logic       pronto_transmissao,
  input  logic       fim_serial,
  input  logic       dois_segundos,
  output logic       reset_circuito,
  output logic       medir,
  output logic       zera_timeout_echo,
  output logic       conta_timeout_echo,
  output logic       partida_serial,
  output logic       zera_contador_ascii,
  output logic       conta_ascii,
  output logic       conta_angulo,
  output logic       db_falha,
  output logic [3:0] db_estado
);

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRIES);

  logic [3:0] state_q, state_d;
  logic [2:0] retry_q, retry_d;
  logic       db_falha_q, db_falha_d;

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    db_falha_d = db_falha_q;
    case (state_q)
      INICIAL: if (ligar) state_d = ESPERA;
      ESPERA: begin
        retry_d = '0;
        if (!ligar)             state_d = INICIAL;
        else if (dois_segundos) state_d = MEDE;
      end
      MEDE:           state_d = AGUARDA_MEDIDA;
      // A completed measurement beats a simultaneous timeout.
      AGUARDA_MEDIDA: begin
        if (pronto_medida)     state_d = TRANSMITE;
        else if (timeout_echo) state_d = FALHA_ECHO;
      end
      FALHA_ECHO: begin
        if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 3'd1;
          state_d = MEDE;
        end else begin
          retry_d    = '0;
          db_falha_d = 1'b1;
          state_d    = AVANCA;
        end
      end
      TRANSMITE:  state_d = AGUARDA_TX;
      AGUARDA_TX: if (pronto_transmissao) state_d = PROXIMO;
      // fim_serial still reflects the selector before this cycle's increment.
      PROXIMO:    state_d = fim_serial ? AVANCA : TRANSMITE;
      AVANCA:     state_d = ESPERA;
      default:    state_d = INICIAL;
    endcase
    if (state_d == INICIAL) db_falha_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INICIAL;
      retry_q    <= '0;
      db_falha_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      db_falha_q <= db_falha_d;
    end
  end

  always_comb begin
    reset_circuito      = 1'b0;
    medir               = 1'b0;
    zera_timeout_echo   = 1'b0;
    conta_timeout_echo  = 1'b0;
    partida_serial      = 1'b0;
    zera_contador_ascii = 1'b0;
    conta_ascii         = 1'b0;
    conta_angulo        = 1'b0;
    case (state_q)
      INICIAL: begin
        reset_circuito      = 1'b1;
        zera_contador_ascii = 1'b1;
        zera_timeout_echo   = 1'b1;
      end
      MEDE: begin
        medir             = 1'b1;
        zera_timeout_echo = 1'b1;
      end
      AGUARDA_MEDIDA: conta_timeout_echo = 1'b1;
      TRANSMITE:      partida_serial     = 1'b1;
      PROXIMO:        conta_ascii        = 1'b1;
      AVANCA: begin
        conta_angulo        = 1'b1;
        zera_contador_ascii = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_falha  = db_falha_q;
  assign db_estado = state_q;

endmodule

// File: doc/sonar_uc.md
Name: sonar_uc

Overview:
- Control unit for the sonar sweep datapath (exp5_fd).
- Drives the datapath's control inputs and reads its status outputs.
- Each sweep step, after the 2 s interval elapses: one HC-SR04 measurement, then the 8-character "AAA,DDD#" frame over serial, then advance the servo angle.
- Adds echo-timeout retry with a bounded retry count and a sticky fault flag.

Parameters:
- MAX_RETRIES, 2, extra measurement attempts after an echo timeout before the angle is skipped (allowed range 0..7).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ligar  in  1  enable sweep; level-sensitive
- pronto_medida  in  1  one-cycle pulse: distance measurement done
- timeout_echo  in  1  echo timeout reached (200 ms counter fim)
- pronto_transmissao  in  1  one-cycle pulse: current character sent
- fim_serial  in  1  ASCII selector at last character (seletor==7)
- dois_segundos  in  1  one-cycle pulse from the free-running 2 s timer
- reset_circuito  out  1  clears the angle counter and the 2 s timer
- medir  out  1  start measurement pulse
- zera_timeout_echo  out  1  clear echo timeout counter
- conta_timeout_echo  out  1  enable echo timeout counter
- partida_serial  out  1  start transmission of the current character
- zera_contador_ascii  out  1  clear ASCII selector
- conta_ascii  out  1  advance ASCII selector
- conta_angulo  out  1  advance servo angle
- db_falha  out  1  sticky: at least one angle skipped after retries were exhausted
- db_estado  out  4  current state code

Behaviour:
- Moore FSM; outputs decoded from the state register only. All transitions occur on the rising edge of clock.
- Synchronous reset:
  - state=INICIAL, retry count=0, db_falha=0.
  - Outputs therefore equal INICIAL's outputs: reset_circuito=1, zera_contador_ascii=1, zera_timeout_echo=1, all others 0, db_estado=0.
- Reset mid-operation aborts immediately at the next edge. No frame completion is required.
- States (code) / asserted outputs / transitions:
  - INICIAL(0): reset_circuito, zera_contador_ascii, zera_timeout_echo. ligar=1 -> ESPERA, else stay.
  - ESPERA(1): retry count cleared. ligar=0 -> INICIAL. Else dois_segundos=1 -> MEDE. ligar=0 has priority when both are set.
  - MEDE(2): medir, zera_timeout_echo; exactly 1 cycle -> AGUARDA_MEDIDA.
  - AGUARDA_MEDIDA(3): conta_timeout_echo.
    - pronto_medida=1 -> TRANSMITE.
    - Else timeout_echo=1 -> FALHA_ECHO.
    - If both are 1 in the same cycle, pronto_medida wins.
  - FALHA_ECHO(4): 1 cycle.
    - If retry count < MAX_RETRIES: count++ and -> MEDE.
    - Else: db_falha<=1, count<=0 and -> AVANCA. No frame is sent.
  - TRANSMITE(5): partida_serial; 1 cycle -> AGUARDA_TX.
  - AGUARDA_TX(6): wait for pronto_transmissao=1 -> PROXIMO. pronto_transmissao is sampled only in this state.
  - PROXIMO(7): conta_ascii, 1 cycle.
    - Uses the fim_serial value present during this cycle, i.e. before the increment.
    - fim_serial=1 -> AVANCA; the selector wraps 7->0 through the counter.
    - Else -> TRANSMITE.
  - AVANCA(8): conta_angulo, zera_contador_ascii; 1 cycle -> ESPERA.
  - Codes 9..15 are illegal and go to INICIAL on the next edge.
- Sequencing guarantees:
  - Exactly 8 partida_serial pulses per successful angle.
  - Exactly one conta_angulo per angle, whether transmitted or skipped.
  - Angle wraps 7->0 in the datapath counter; the controller does not track the angle.
- dois_segundos pulses that arrive outside ESPERA are ignored. The next step waits for the next pulse.
- ligar=0 is honoured only in ESPERA. An angle step in progress always completes.
- Retry counter width is 3 bits. db_falha is cleared only by reset or by entering INICIAL.

Decomposition:
- Package sonar_uc_pkg holds:
  - the 4-bit state encoding constants INICIAL..AVANCA;
  - the MAX_RETRIES default;
  - the frame length constant 8.
- No sub-module is needed; the retry counter is inline.
- The top-level wrapper instantiates sonar_uc beside exp5_fd.

Test Plan:
- Reset then ligar=1, one dois_segundos pulse, pronto_medida 5 cycles after medir, pronto_transmissao 10 cycles after each partida -> medir 1 pulse; partida_serial 8 pulses; conta_ascii 8 pulses; conta_angulo 1 pulse; returns to db_estado=1.
- timeout_echo asserted on 2 consecutive attempts, then pronto_medida, with MAX_RETRIES=2 -> medir 3 pulses; 8 characters sent; db_falha=0.
- timeout_echo on 3 consecutive attempts, MAX_RETRIES=2 -> medir 3 pulses; partida_serial 0; conta_angulo 1; db_falha=1 sticky across the next successful angle.
- pronto_medida and timeout_echo in the same cycle -> goes to TRANSMITE; count unchanged.
- ligar dropped during AGUARDA_TX -> frame finishes (8 characters); conta_angulo=1; ESPERA -> INICIAL; reset_circuito=1.
- reset asserted during TRANSMITE -> next edge db_estado=0; partida_serial=0; db_falha=0; dois_segundos pulse in INICIAL with ligar=0 ignored.
